// File: rtl/snn_seq_pkg.sv
// snn_seq_pkg: state encoding, default sizes and result record shared by the beat sequencer.
package snn_seq_pkg;
  localparam int DEF_N_SAMPLES = 256;
  localparam int DEF_DATA_W = 6;
  localparam int DEF_HOLD_CYC = 3;
  localparam int DEF_TIMEOUT_CYC = 1048576;
  localparam int RES_CYC_W = 21;
  typedef enum logic [2:0] {IDLE, LOAD, PAD, HOLD, RUN} state_e;
  typedef struct packed {
    logic [1:0]           cls;
    logic                 no_spike;
    logic                 timeout;
    logic                 frame_err;
    logic [RES_CYC_W-1:0] cycles;
  } result_t;
endpackage

// File: rtl/snn_seq_result_reg.sv
// snn_seq_result_reg: 1-deep valid/ready holding register for one beat result.
module snn_seq_result_reg
  import snn_seq_pkg::*;
(
  input  logic    clk,
  input  logic    resetn,
  input  logic    load_i,
  input  result_t data_i,
  input  logic    ready_i,
  output logic    valid_o,
  output logic    free_o,
  output result_t data_o
);
  logic    valid_q, valid_d;
  result_t data_q, data_d;
  always_comb begin
    free_o  = !valid_q || ready_i;
    valid_d = load_i || (valid_q && !ready_i);
    data_d  = load_i ? data_i : data_q;
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
endmodule

// File: rtl/snn_beat_sequencer.sv
// snn_beat_sequencer: loads one framed heartbeat into the classifier core, runs it,
// and captures class / no-spike / latency into a valid/ready result register.
module snn_beat_sequencer
  import snn_seq_pkg::*;
#(
  parameter int N_SAMPLES   = DEF_N_SAMPLES,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = $clog2(N_SAMPLES),
  parameter int HOLD_CYC    = DEF_HOLD_CYC,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int CYC_W       = RES_CYC_W
)(
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              core_rst_hold,
  output logic              core_wr_en,
  output logic [ADDR_W-1:0] core_wr_addr,
  output logic [DATA_W-1:0] core_wr_data,
  input  logic              core_end_process,
  input  logic [1:0]        core_output_class,
  input  logic              core_no_spike,
  output logic              r_valid,
  input  logic              r_ready,
  output logic [1:0]        r_class,
  output logic              r_no_spike,
  output logic              r_timeout,
  output logic              r_frame_err,
  output logic [CYC_W-1:0]  r_cycles,
  output logic [15:0]       beat_count,
  output logic              busy
);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);
  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, waddr;
  logic [7:0]        hold_q, hold_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d, cyc_n;
  logic [15:0]       beats_q, beats_d;
  logic              fe_q, fe_d, accept, done, cap, free;
  result_t           res_d, res_q;
  always_comb begin
    s_ready       = resetn && (state_q == IDLE || state_q == LOAD);
    accept        = s_valid && s_ready;
    waddr         = (state_q == IDLE) ? '0 : idx_q;
    core_wr_en    = accept || (resetn && state_q == PAD);
    core_wr_addr  = waddr;
    core_wr_data  = (state_q == PAD) ? '0 : s_data;
    core_rst_hold = !resetn || state_q != RUN;
    busy          = state_q != IDLE;
    cyc_n         = cyc_q + 1'b1;
    done          = state_q == RUN && (core_end_process || cyc_n == CYC_W'(TIMEOUT_CYC));
    cap           = done && free;
    // end_process takes priority over a coincident timeout
    res_d.cls       = core_end_process ? core_output_class : 2'd0;
    res_d.no_spike  = core_end_process ? core_no_spike : 1'b1;
    res_d.timeout   = !core_end_process;
    res_d.frame_err = fe_q;
    res_d.cycles    = RES_CYC_W'(cyc_n);
    beats_d = beats_q + 16'(cap);
    state_d = state_q;
    idx_d   = idx_q;
    fe_d    = fe_q;
    hold_d  = '0;
    cyc_d   = '0;
    case (state_q)
      IDLE, LOAD: if (accept) begin
        idx_d   = waddr + 1'b1;
        state_d = LOAD;
        if (waddr == LAST_IDX) begin
          state_d = HOLD;
          fe_d    = !s_last;
        end else if (s_last) begin
          state_d = PAD;
          fe_d    = 1'b1;
        end
      end
      PAD: begin
        idx_d   = idx_q + 1'b1;
        state_d = (idx_q == LAST_IDX) ? HOLD : PAD;
      end
      HOLD: begin
        hold_d  = hold_q + 1'b1;
        state_d = (hold_q == 8'(HOLD_CYC - 1)) ? RUN : HOLD;
      end
      RUN: begin
        // a finished run waiting on a full result register keeps its count frozen
        cyc_d   = done ? cyc_q : cyc_n;
        state_d = cap ? IDLE : RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!resetn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
      cyc_q   <= '0;
      fe_q    <= 1'b0;
      beats_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      fe_q    <= fe_d;
      beats_q <= beats_d;
    end
  snn_seq_result_reg u_res (
    .clk     (clk),
    .resetn  (resetn),
    .load_i  (cap),
    .data_i  (res_d),
    .ready_i (r_ready),
    .valid_o (r_valid),
    .free_o  (free),
    .data_o  (res_q)
  );
  assign r_class     = res_q.cls;
  assign r_no_spike  = res_q.no_spike;
  assign r_timeout   = res_q.timeout;
  assign r_frame_err = res_q.frame_err;
  assign r_cycles    = CYC_W'(res_q.cycles);
  assign beat_count  = beats_q;
endmodule
